// File: rtl/heap_arbiter_pkg.sv
// Shared types and default sizing for the heap arbiter and its round-robin picker.
package heap_arbiter_pkg;

  typedef enum logic [0:0] {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF         = 3;
  localparam int ADDR_WIDTH_DEF   = 12;
  localparam int DATA_WIDTH_DEF   = 12;
  localparam int LOCK_TIMEOUT_DEF = 16;
  localparam int IDX_W_DEF        = $clog2(NREQ_DEF);

endpackage

// File: rtl/heap_rr_pick.sv
// Combinational round-robin selector: first masked valid requester at or after ptr.
module heap_rr_pick
  import heap_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  logic [NREQ-1:0]  cand_s;
  logic [IDX_W-1:0] pos_s;

  assign cand_s = valid & mask;

  // Scan the candidates starting at ptr and wrapping around; the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos_s = IDX_W'((int'(ptr) + i) % NREQ);
      if (!found && cand_s[pos_s]) begin
        grant[pos_s] = 1'b1;
        index        = pos_s;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing the single-port heap among NREQ requesters,
// with a lock for exclusive read-modify-write sequences released on timeout.
module heap_arbiter
  import heap_arbiter_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ-1:0]            req_lock,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       mem_write,
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic [DATA_WIDTH-1:0]      mem_in,
  input  logic [DATA_WIDTH-1:0]      mem_out,
  output logic [$clog2(NREQ)-1:0]    lock_owner,
  output logic                       locked
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_TIMEOUT - 1);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic                   mem_write_q;
  logic [ADDR_WIDTH-1:0]  mem_address_q;
  logic [DATA_WIDTH-1:0]  mem_in_q;
  logic [NREQ-1:0]        tag_q;
  logic [NREQ-1:0]        rsp_valid_q;

  logic [NREQ-1:0]        mask_s;
  logic [NREQ-1:0]        grant_s;
  logic [IDX_W-1:0]       gidx_s;
  logic                   found_s;
  logic                   accept_s;
  logic                   sel_write_s;
  logic                   sel_lock_s;
  logic [ADDR_WIDTH-1:0]  sel_addr_s;
  logic [DATA_WIDTH-1:0]  sel_data_s;

  heap_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .mask  (mask_s),
    .grant (grant_s),
    .index (gidx_s),
    .found (found_s)
  );

  // Ready is forced low while reset is held so nothing is offered during reset.
  assign req_ready = grant_s & {NREQ{reset}};
  assign accept_s  = found_s & reset;

  // Fields of the granted requester.
  always_comb begin
    sel_write_s = req_write[gidx_s];
    sel_lock_s  = req_lock[gidx_s];
    sel_addr_s  = req_address[int'(gidx_s) * ADDR_WIDTH +: ADDR_WIDTH];
    sel_data_s  = req_data[int'(gidx_s) * DATA_WIDTH +: DATA_WIDTH];
  end

  // State register with lock owner, idle counter and rotation pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= FREE;
      lock_owner_q <= '0;
      idle_cnt_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      idle_cnt_q   <= idle_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // Next-state logic: lock on a locked acceptance, release on unlock or idle timeout.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    idle_cnt_d   = idle_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept_s) begin
      rr_ptr_d = (gidx_s == LAST_IDX) ? '0 : gidx_s + IDX_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case (state_q)
      FREE: begin
        if (accept_s && sel_lock_s) begin
          state_d      = LOCKED;
          lock_owner_d = gidx_s;
          idle_cnt_d   = '0;
        end else begin
          state_d = FREE;
        end
      end
      LOCKED: begin
        if (accept_s) begin
          idle_cnt_d = '0;
          state_d    = sel_lock_s ? LOCKED : FREE;
        end else if (idle_cnt_q == CNT_LIMIT) begin
          idle_cnt_d = '0;
          state_d    = FREE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = FREE;
        idle_cnt_d = '0;
      end
    endcase
  end

  // FSM outputs: the eligibility mask handed to the picker.
  always_comb begin
    mask_s = '1;
    case (state_q)
      FREE:    mask_s = '1;
      LOCKED:  mask_s = NREQ'(1'b1) << lock_owner_q;
      default: mask_s = '0;
    endcase
  end

  // Issue registers and two-stage response tag; mem_write is a single-cycle strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      tag_q         <= '0;
      rsp_valid_q   <= '0;
    end else begin
      mem_write_q <= accept_s & sel_write_s;
      if (accept_s) begin
        mem_address_q <= sel_addr_s;
        mem_in_q      <= sel_data_s;
      end
      tag_q       <= accept_s ? grant_s : '0;
      rsp_valid_q <= tag_q;
    end
  end

  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_in      = mem_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = mem_out;
  assign lock_owner  = lock_owner_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_heap_arbiter.sv
// Directed bench for heap_arbiter with a write-first heap model and a response scoreboard.
module tb_heap_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  req_ready;
  logic [2:0]  req_write = 3'b000;
  logic [2:0]  req_lock = 3'b000;
  logic [35:0] req_address = 36'h0;
  logic [35:0] req_data = 36'h0;
  logic [2:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic        mem_write;
  logic [11:0] mem_address;
  logic [11:0] mem_in;
  logic [11:0] mem_out = 12'h000;
  logic [1:0]  lock_owner;
  logic        locked;

  typedef struct {
    logic [2:0]  who;
    logic [11:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] ref_mem [0:4095];
  logic [11:0] heap_mem [0:4095];
  bit          heap_vld [0:4095];
  int          n_assert = 0;
  int          n_fail = 0;

  heap_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_lock    (req_lock),
    .req_address (req_address),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_out     (mem_out),
    .lock_owner  (lock_owner),
    .locked      (locked)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] init_val(input logic [11:0] a);
    if (a == 12'd5) return 12'h0A3;
    else if (a >= 12'd20 && a < 12'd26) return 12'h100 + (a - 12'd20);
    else return a ^ 12'h5A5;
  endfunction

  // Heap model: one-cycle registered output, written value appears on mem_out.
  always @(posedge clock) begin
    if (mem_write) begin
      heap_mem[mem_address] <= mem_in;
      heap_vld[mem_address] <= 1'b1;
      mem_out <= mem_in;
    end else begin
      mem_out <= heap_vld[mem_address] ? heap_mem[mem_address] : init_val(mem_address);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic w, input logic l,
                         input logic [11:0] a, input logic [11:0] d);
    req_valid[r] = v;
    req_write[r] = w;
    req_lock[r]  = l;
    req_address[r*12 +: 12] = a;
    req_data[r*12 +: 12]    = d;
  endtask

  task automatic idle_all();
    for (int r = 0; r < 3; r++) set_req(r, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
  endtask

  // Check the grant for the inputs just driven and queue the response it implies.
  task automatic issue(input string tag, input logic [2:0] exp_ready, input bit push);
    exp_t        e;
    logic [11:0] a;
    #1;
    chk(tag, {29'h0, req_ready}, {29'h0, exp_ready});
    if (push) begin
      for (int g = 0; g < 3; g++) begin
        if (exp_ready[g]) begin
          a     = req_address[g*12 +: 12];
          e.who = exp_ready;
          if (req_write[g]) begin
            e.data     = req_data[g*12 +: 12];
            ref_mem[a] = e.data;
          end else begin
            e.data = ref_mem[a];
          end
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {29'h0, req_ready}, 32'h0);
    chk({tag, "_rsp"}, {29'h0, rsp_valid}, 32'h0);
    chk({tag, "_memw"}, {31'h0, mem_write}, 32'h0);
    chk({tag, "_addr"}, {20'h0, mem_address}, 32'h0);
    chk({tag, "_in"}, {20'h0, mem_in}, 32'h0);
    chk({tag, "_locked"}, {31'h0, locked}, 32'h0);
    chk({tag, "_owner"}, {30'h0, lock_owner}, 32'h0);
  endtask

  // Response monitor: every pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    exp_t e;
    if (rsp_valid !== 3'b000) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected: rsp_valid=%b with no request outstanding", rsp_valid);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_valid", {29'h0, rsp_valid}, {29'h0, e.who});
        chk("rsp_data", {20'h0, rsp_data}, {20'h0, e.data});
      end
    end
  end

  initial begin
    logic [2:0] exp_r;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));

    // Reset held with a requester valid: everything must read zero.
    set_req(1, 1'b1, 1'b0, 1'b0, 12'd4, 12'h000);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk_reset_outputs("reset0");
    @(negedge clock);
    idle_all();
    reset = 1'b1;

    // All three valid from rr_ptr=0: strict rotation.
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      for (int r = 0; r < 3; r++) set_req(r, 1'b1, 1'b0, 1'b0, 12'(20 + c), 12'h000);
      exp_r = 3'b001 << (c % 3);
      issue("rr_grant", exp_r, 1'b1);
    end
    @(negedge clock);
    idle_all();

    // Single read of a preloaded location.
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 1'b0, 12'd5, 12'h000);
    issue("single_read", 3'b001, 1'b1);
    @(negedge clock);
    idle_all();

    // Write then back-to-back read from another requester.
    @(negedge clock);
    set_req(1, 1'b1, 1'b1, 1'b0, 12'd9, 12'h7FF);
    issue("wr_grant", 3'b010, 1'b1);
    @(negedge clock);
    set_req(1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    set_req(2, 1'b1, 1'b0, 1'b0, 12'd9, 12'h000);
    issue("raw_grant", 3'b100, 1'b1);
    chk("mem_write_hi", {31'h0, mem_write}, 32'h1);
    chk("mem_address", {20'h0, mem_address}, 32'h9);
    chk("mem_in", {20'h0, mem_in}, 32'h7FF);
    @(negedge clock);
    idle_all();
    #1;
    chk("mem_write_lo", {31'h0, mem_write}, 32'h0);

    // Lock by r0 blocks r1 until r0 unlocks with a write.
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 1'b1, 12'd3, 12'h000);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'd4, 12'h000);
    issue("lock_take", 3'b001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      set_req(0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
      issue("lock_block", 3'b000, 1'b0);
      chk("lock_locked", {31'h0, locked}, 32'h1);
      chk("lock_owner0", {30'h0, lock_owner}, 32'h0);
    end
    @(negedge clock);
    set_req(0, 1'b1, 1'b1, 1'b0, 12'd3, 12'h055);
    issue("lock_release_wr", 3'b001, 1'b1);
    @(negedge clock);
    set_req(0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    issue("after_unlock", 3'b010, 1'b1);
    chk("unlocked", {31'h0, locked}, 32'h0);
    @(negedge clock);
    idle_all();

    // r2 takes the lock and goes idle; r0 waits out the timeout.
    @(negedge clock);
    set_req(2, 1'b1, 1'b0, 1'b1, 12'd7, 12'h000);
    issue("to_take", 3'b100, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      set_req(2, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
      set_req(0, 1'b1, 1'b0, 1'b0, 12'd5, 12'h000);
      issue("to_wait", 3'b000, 1'b0);
      chk("to_locked", {31'h0, locked}, 32'h1);
      chk("to_owner2", {30'h0, lock_owner}, 32'h2);
    end
    @(negedge clock);
    issue("to_grant", 3'b001, 1'b1);
    chk("to_released", {31'h0, locked}, 32'h0);
    @(negedge clock);
    idle_all();

    // Reset one cycle after an accepted read: the response must never appear.
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 1'b0, 12'd6, 12'h321);
    issue("pre_rst", 3'b001, 1'b0);
    @(negedge clock);
    idle_all();
    set_req(1, 1'b1, 1'b0, 1'b0, 12'd4, 12'h000);
    reset = 1'b0;
    #1;
    chk_reset_outputs("reset1");
    @(negedge clock);
    #1;
    chk("rst_rsp_hold", {29'h0, rsp_valid}, 32'h0);
    @(negedge clock);
    idle_all();
    reset = 1'b1;
    @(negedge clock);
    for (int r = 0; r < 3; r++) set_req(r, 1'b1, 1'b0, 1'b0, 12'd21, 12'h000);
    issue("post_rst", 3'b001, 1'b1);
    @(negedge clock);
    issue("post_rst2", 3'b010, 1'b1);
    @(negedge clock);
    idle_all();

    repeat (4) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/heap_arbiter.md
# heap_arbiter

Round-robin arbiter that shares the single-port `heapMemory` between up to `NREQ` requesters, for example the instruction executor, the array allocator and the array-shift engine. It accepts at most one request per cycle through a valid/ready handshake and drives the registered heap ports. It routes the one-cycle-delayed heap output back to the issuing requester, tagged by a one-hot response valid. A lock mechanism gives one requester exclusive access for read-modify-write sequences, bounded by a timeout.

## Interface
- `NREQ`, 3: number of requesters (2..8).
- `ADDR_WIDTH`, 12: heap address width (matches heap `MEM_SIZE`).
- `DATA_WIDTH`, 12: heap element width (matches `MemoryElementWidth`).
- `LOCK_TIMEOUT`, 16: idle cycles after which a held lock is forcibly released.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request present, per requester.
- `req_ready` out NREQ: request accepted this cycle (one-hot or zero).
- `req_write` in NREQ: 1 = write, 0 = read.
- `req_lock` in NREQ: keep the grant after this access.
- `req_address` in NREQ*ADDR_WIDTH: packed addresses, requester i at slice i.
- `req_data` in NREQ*DATA_WIDTH: packed write data.
- `rsp_valid` out NREQ: one-hot response strobe.
- `rsp_data` out DATA_WIDTH: read data, or the written value for writes.
- `mem_write`, `mem_address`, `mem_in` out: registered heap ports.
- `mem_out` in DATA_WIDTH: heap output.
- `lock_owner` out $clog2(NREQ): current lock holder (valid when `locked`).
- `locked` out 1: lock held.

## Operation
- States:
  - FREE: round-robin arbitration over `req_valid`, starting at `rr_ptr`.
  - LOCKED: only `lock_owner` may be granted; `req_ready` is 0 for all others.
- Grant:
  - `req_ready[g]` is combinational from `req_valid`, state and `rr_ptr`.
  - Acceptance happens when `req_valid[g] && req_ready[g]`.
  - On acceptance, `rr_ptr <= (g+1) mod NREQ`.
- FREE→LOCKED: an accepted request has `req_lock`=1. Set `lock_owner=g`.
- LOCKED→FREE:
  - An accepted owner request has `req_lock`=0, or
  - the owner makes no request for `LOCK_TIMEOUT` consecutive cycles. The idle counter resets on every owner acceptance.
- Heap port control:
  - `mem_write` is 1 only in the cycle after an accepted write. It is 0 on every other cycle, because the heap rewrites on every edge while `mem_write`=1.
  - `mem_address` and `mem_in` hold their last value when idle.
- Response:
  - Every accepted request produces exactly one `rsp_valid` pulse to its issuer; reads and writes both get one.
  - There is no response back-pressure; requesters must sample the pulse.

## Timing
- Request accepted at edge T: `mem_*` are registered at T and the heap captures at T+1.
- `rsp_valid[g]` is high for exactly one cycle, between edges T+1 and T+2, with `rsp_data = mem_out`.
- Throughput is one access per cycle, back-to-back, across any mix of requesters.
- Read-after-write from any requester in consecutive cycles returns the new data.
- Reset values, all applied asynchronously on `reset`=0:
  - `req_ready`, `rsp_valid`, `mem_write`, `mem_address`, `mem_in`, `locked`, `lock_owner` = 0.
  - `rr_ptr` = 0, state = FREE.
- Reset mid-operation: in-flight accesses are dropped; no `rsp_valid` pulse appears after reset asserts.
- Simultaneous events:
  - An owner request with `req_lock`=0 on the timeout cycle: the request is accepted and the lock released once, with no double grant.
  - All requesters valid in FREE: strict rotation with no starvation; worst-case wait is NREQ-1 cycles.

## Structure
- Package `heap_arbiter_pkg` holds:
  - the `arb_state_t` enum (FREE, LOCKED);
  - default width constants;
  - the `$clog2`-derived index width.
- Sub-module `heap_rr_pick`: combinational round-robin one-hot selector taking `valid`, `ptr` and a `mask` for lock-restricted selection. It returns the one-hot grant and the index.
- The top level holds `rr_ptr`, the state register, the timeout counter, the issue registers and the response tag pipeline.

## Test plan
- Single read: heap[5]=0x0A3, r0 reads address 5 → `rsp_valid`=3'b001 two edges later, `rsp_data`=0x0A3.
- All three requesters valid for 6 cycles, `rr_ptr`=0 → grant order 0,1,2,0,1,2; each sees 2 responses with matching data.
- Write then read: r1 writes 0x7FF to address 9, then r2 reads 9 on the next cycle → r2 receives 0x7FF. `mem_write` is high for exactly one cycle.
- Lock: r0 reads address 3 with lock, r1 is valid throughout → r1 `req_ready`=0 until r0 writes address 3 with `req_lock`=0, then r1 is granted the next cycle.
- Timeout: r2 takes the lock then goes idle, `LOCK_TIMEOUT`=16 → `locked` drops after 16 idle cycles, and a pending r0 is granted on the following cycle.
- Reset pulse one cycle after a read is accepted → no `rsp_valid`, all outputs 0, and the first grant after reset goes to r0.
